reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//   Parametrised configuration register file for the UART system: DEPTH x DATA_W storage with per-register
//   reset values, a read-only mask, and address/collision error reporting. It also provides a sequenced
//   clear-to-defaults sweep and a flattened config bus of the low CFG_REGS registers for UART/prescale logic.
//   It sits between the system controller (which issues reads and writes) and the UART TX/RX configuration inputs.
// PARAMETERS
//   DATA_W    8        register width, bits
//   ADDR_W    4        address width
//   DEPTH     16       number of registers, 1..2**ADDR_W
//   CFG_REGS  4        registers exported on CfgBus, 1..DEPTH
//   RST_VALS  {..,8'h20,8'h81,8'h00,8'h00}  packed DEPTH*DATA_W; reg i default = RST_VALS[i*DATA_W +: DATA_W]
//   RO_MASK   0        DEPTH bits; bit i=1 makes reg i read-only from the bus
// PORTS
//   clk           in   1                 clock, rising edge
//   rst           in   1                 asynchronous, active-low reset
//   address       in   ADDR_W            register index
//   WrEn          in   1                 write strobe
//   RdEn          in   1                 read strobe
//   WrData        in   DATA_W            write data
//   ClrReq        in   1                 request sweep of all regs to RST_VALS
//   RdData        out  DATA_W            read data, registered
//   RdData_Valid  out  1                 1-cycle pulse qualifying RdData
//   AddrErr       out  1                 1-cycle pulse: bad address, RO write, or RdEn&WrEn collision
//   Busy          out  1                 high while the clear sweep runs
//   CfgBus        out  CFG_REGS*DATA_W   reg0 at LSBs; combinational from storage
//   ParErr        out  1                 only with REGFILE_PARITY_EN
// BEHAVIOUR
//   - Reset (rst=0, async): reg i <= RST_VALS slice; RdData=0, RdData_Valid=0, AddrErr=0, Busy=0, FSM=IDLE, sweep cnt=0.
//   - FSM IDLE/CLEAR. IDLE & ClrReq -> CLEAR, cnt=0. ClrReq has priority over a same-cycle WrEn/RdEn,
//     which is dropped (no Valid, no AddrErr).
//   - CLEAR: each cycle reg[cnt] <= RST_VALS slice (RO regs included), cnt++. At cnt==DEPTH-1, write the
//     last reg and return to IDLE. Busy=1 for exactly DEPTH cycles, starting the cycle after ClrReq is sampled.
//     WrEn, RdEn and ClrReq are ignored; Valid=0 and AddrErr=0 throughout.
//   - IDLE only; all accesses are evaluated at the rising edge:
//     WrEn&!RdEn: if address<DEPTH and RO_MASK[address]=0 -> reg written, visible on CfgBus next cycle;
//       otherwise no write and AddrErr=1 for one cycle.
//     RdEn&!WrEn: address<DEPTH -> RdData<=reg, Valid=1 next cycle (1-cycle latency);
//       out of range -> RdData<=0, Valid=1, AddrErr=1.
//     RdEn&WrEn: no access, Valid=0, AddrErr=1.
//     Neither: Valid=0, AddrErr=0, RdData holds its last value.
//   - Back-to-back reads: one result per cycle. Read of a reg written the previous cycle returns the new value.
//   - Reset asserted mid-CLEAR aborts the sweep; every reg takes its reset value regardless.
// CONFIGURATION
//   REGFILE_PARITY_EN defined: each reg stores an even-parity bit, set on write, sweep and reset.
//     On a valid in-range read, a recomputed-parity mismatch gives ParErr=1 with Valid; otherwise ParErr=0. ParErr resets to 0.
//   Not defined: no parity storage; ParErr port absent; all other behaviour identical.
// TESTING
//   1. Release reset, RdEn addr 2 then addr 3 -> RdData 0x81, then 0x20, each with Valid one cycle after RdEn.
//   2. Write 0xA5 @5 then read @5 -> 0xA5. Write 0x3C @1 -> CfgBus[15:8]=0x3C the next cycle.
//   3. RO_MASK=16'h0010: write 0xFF @4 -> AddrErr pulse, read @4 -> 0x00. RdEn&WrEn @6 -> AddrErr=1, Valid=0, reg6 unchanged.
//   4. DEPTH=12: RdEn @13 -> RdData=0, Valid=1, AddrErr=1. WrEn @12 -> AddrErr=1, no write.
//   5. Write 0x55 to all regs, pulse ClrReq -> Busy high 16 cycles; RdEn during sweep -> no Valid.
//      Afterwards reads return RST_VALS (reg2=0x81). Reset at sweep cycle 7 -> Busy=0 and all defaults.
//   6. With REGFILE_PARITY_EN: write 0x0F @7, force the stored parity bit inverted, read @7 -> Valid=1, ParErr=1;
//      read @2 -> ParErr=0.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised UART configuration register file: reset defaults, read-only mask, error pulses,
// clear-to-defaults sweep and a flat config bus. Optional parity storage under REGFILE_PARITY_EN.
module reg_file_param #(
   parameter int                         DATA_W   = 8,
   parameter int                         ADDR_W   = 4,
   parameter int                         DEPTH    = 16,
   parameter int                         CFG_REGS = 4,
   parameter logic [DEPTH*DATA_W-1:0]    RST_VALS = (DEPTH*DATA_W)'(32'h2081_0000),
   parameter logic [DEPTH-1:0]           RO_MASK  = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            address,
   input  logic                         WrEn,
   input  logic                         RdEn,
   input  logic [DATA_W-1:0]            WrData,
   input  logic                         ClrReq,
   output logic [DATA_W-1:0]            RdData,
   output logic                         RdData_Valid,
   output logic                         AddrErr,
   output logic                         Busy,
   output logic [CFG_REGS*DATA_W-1:0]   CfgBus
`ifdef REGFILE_PARITY_EN
   ,
   output logic                         ParErr
`endif
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              addr_err_q, addr_err_d;

   logic [DATA_W-1:0] sel_word;
   logic              ro_hit;
   logic              in_range;
   logic              wr_ok;
   logic              rd_hit;
   logic              clr_wr;

   function automatic logic [DATA_W-1:0] rst_val(input int idx);
      return RST_VALS[idx*DATA_W +: DATA_W];
   endfunction

   // Address decode; out-of-range addresses simply match no register.
   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      sel_word = '0;
      ro_hit   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (address == ADDR_W'(i)) begin
            sel_word = mem_q[i];
            ro_hit   = RO_MASK[i];
         end
      end
   end

   assign in_range = ({1'b0, address} < (ADDR_W+1)'(DEPTH));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      addr_err_d = 1'b0;
      wr_ok      = 1'b0;
      rd_hit     = 1'b0;
      clr_wr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ClrReq) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else if (WrEn && RdEn) begin
               addr_err_d = 1'b1;
            end else if (WrEn) begin
               if (in_range && !ro_hit) wr_ok = 1'b1;
               else                     addr_err_d = 1'b1;
            end else if (RdEn) begin
               rd_valid_d = 1'b1;
               if (in_range) begin
                  rd_hit    = 1'b1;
                  rd_data_d = sel_word;
               end else begin
                  rd_data_d  = '0;
                  addr_err_d = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            // Bus traffic is ignored for the whole sweep; read-only registers are restored too.
            clr_wr = 1'b1;
            if (cnt_q == ADDR_W'(DEPTH-1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (clr_wr && (cnt_q == ADDR_W'(i)))
            mem_d[i] = rst_val(i);
         else if (wr_ok && (address == ADDR_W'(i)))
            mem_d[i] = WrData;
      end
   end

   // NOTE: the storage array is reset like any other flop because each register has a defined default.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= rst_val(i);
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         addr_err_q <= addr_err_d;
         mem_q      <= mem_d;
      end
   end

`ifdef REGFILE_PARITY_EN
   logic [DEPTH-1:0] par_q, par_d;
   logic             sel_par;
   logic             par_err_q, par_err_d;

   always_comb begin
      sel_par = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (address == ADDR_W'(i)) sel_par = par_q[i];
      end
   end

   // Even parity: the stored bit equals the XOR of the data bits.
   always_comb begin
      par_d     = par_q;
      par_err_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (clr_wr && (cnt_q == ADDR_W'(i)))
            par_d[i] = ^rst_val(i);
         else if (wr_ok && (address == ADDR_W'(i)))
            par_d[i] = ^WrData;
      end
      if (rd_hit) par_err_d = (^sel_word) ^ sel_par;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_err_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) par_q[i] <= ^rst_val(i);
      end else begin
         par_err_q <= par_err_d;
         par_q     <= par_d;
      end
   end

   assign ParErr = par_err_q;
`endif

   always_comb begin
      CfgBus = '0;
      for (int i = 0; i < CFG_REGS; i++) CfgBus[i*DATA_W +: DATA_W] = mem_q[i];
   end

   assign RdData       = rd_data_q;
   assign RdData_Valid = rd_valid_q;
   assign AddrErr      = addr_err_q;
   assign Busy         = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: a 16-deep instance with reg4 read-only and a 12-deep instance.
module tb_reg_file_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // 16-deep instance, reg4 read-only, default reset values
   logic [3:0]  a_addr;
   logic        a_wr, a_rd, a_clr;
   logic [7:0]  a_wdata, a_rdata;
   logic        a_valid, a_err, a_busy;
   logic [31:0] a_cfg;

   // 12-deep instance, nothing read-only
   logic [3:0]  b_addr;
   logic        b_wr, b_rd, b_clr;
   logic [7:0]  b_wdata, b_rdata;
   logic        b_valid, b_err, b_busy;
   logic [31:0] b_cfg;

`ifdef REGFILE_PARITY_EN
   logic        a_par, b_par;
`endif

   reg_file_param #(
      .DATA_W(8), .ADDR_W(4), .DEPTH(16), .CFG_REGS(4), .RO_MASK(16'h0010)
   ) dut_a (
      .clk(clk), .rst(rst), .address(a_addr), .WrEn(a_wr), .RdEn(a_rd), .WrData(a_wdata),
      .ClrReq(a_clr), .RdData(a_rdata), .RdData_Valid(a_valid), .AddrErr(a_err),
      .Busy(a_busy), .CfgBus(a_cfg)
`ifdef REGFILE_PARITY_EN
      , .ParErr(a_par)
`endif
   );

   reg_file_param #(
      .DATA_W(8), .ADDR_W(4), .DEPTH(12), .CFG_REGS(4),
      .RST_VALS(96'h0000_0000_0000_0000_2081_0000), .RO_MASK(12'h000)
   ) dut_b (
      .clk(clk), .rst(rst), .address(b_addr), .WrEn(b_wr), .RdEn(b_rd), .WrData(b_wdata),
      .ClrReq(b_clr), .RdData(b_rdata), .RdData_Valid(b_valid), .AddrErr(b_err),
      .Busy(b_busy), .CfgBus(b_cfg)
`ifdef REGFILE_PARITY_EN
      , .ParErr(b_par)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard for dut_a read data: pushed when a read is driven, popped when Valid appears.
   logic [7:0] sb_q[$];

   always @(negedge clk) begin
      if (rst && a_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got RdData_Valid=1 with 0x%0h, expected no read result", a_rdata);
         end else begin
            check("rd_data", {24'h0, a_rdata}, {24'h0, sb_q.pop_front()});
         end
      end
   end

   function automatic logic [7:0] dflt(input int idx);
      case (idx)
         2:       return 8'h81;
         3:       return 8'h20;
         default: return 8'h00;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic wr, input logic rd, input logic clr,
                          input logic [3:0] addr, input logic [7:0] wdata);
      a_wr = wr; a_rd = rd; a_clr = clr; a_addr = addr; a_wdata = wdata;
   endtask

   task automatic drive_b(input logic wr, input logic rd, input logic [3:0] addr,
                          input logic [7:0] wdata);
      b_wr = wr; b_rd = rd; b_addr = addr; b_wdata = wdata;
   endtask

   typedef struct {
      logic        wr;
      logic        rd;
      logic [3:0]  addr;
      logic [7:0]  wdata;
      logic        exp_valid;
      logic        exp_err;
      logic [7:0]  exp_data;
      logic [31:0] exp_cfg;
   } vec_t;

   function automatic vec_t mk(input logic wr, input logic rd, input logic [3:0] addr,
                               input logic [7:0] wdata, input logic ev, input logic ee,
                               input logic [7:0] ed, input logic [31:0] ec);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
      v.exp_valid = ev; v.exp_err = ee; v.exp_data = ed; v.exp_cfg = ec;
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[20];
      logic [7:0] last_data;
      int         busy_cnt;

      vecs[0]  = mk(0, 1, 4'd2,  8'h00, 1, 0, 8'h81, 32'h2081_0000);
      vecs[1]  = mk(0, 1, 4'd3,  8'h00, 1, 0, 8'h20, 32'h2081_0000);
      vecs[2]  = mk(0, 0, 4'd0,  8'h00, 0, 0, 8'h00, 32'h2081_0000);
      vecs[3]  = mk(1, 0, 4'd5,  8'hA5, 0, 0, 8'h00, 32'h2081_0000);
      vecs[4]  = mk(0, 1, 4'd5,  8'h00, 1, 0, 8'hA5, 32'h2081_0000);
      vecs[5]  = mk(1, 0, 4'd1,  8'h3C, 0, 0, 8'h00, 32'h2081_3C00);
      vecs[6]  = mk(1, 0, 4'd4,  8'hFF, 0, 1, 8'h00, 32'h2081_3C00);
      vecs[7]  = mk(0, 1, 4'd4,  8'h00, 1, 0, 8'h00, 32'h2081_3C00);
      vecs[8]  = mk(1, 1, 4'd6,  8'h77, 0, 1, 8'h00, 32'h2081_3C00);
      vecs[9]  = mk(0, 1, 4'd6,  8'h00, 1, 0, 8'h00, 32'h2081_3C00);
      vecs[10] = mk(1, 0, 4'd0,  8'h5A, 0, 0, 8'h00, 32'h2081_3C5A);
      vecs[11] = mk(0, 1, 4'd0,  8'h00, 1, 0, 8'h5A, 32'h2081_3C5A);
      vecs[12] = mk(0, 1, 4'd1,  8'h00, 1, 0, 8'h3C, 32'h2081_3C5A);
      vecs[13] = mk(0, 1, 4'd15, 8'h00, 1, 0, 8'h00, 32'h2081_3C5A);
      vecs[14] = mk(1, 0, 4'd3,  8'hC3, 0, 0, 8'h00, 32'hC381_3C5A);
      vecs[15] = mk(0, 1, 4'd3,  8'h00, 1, 0, 8'hC3, 32'hC381_3C5A);
      vecs[16] = mk(1, 0, 4'd15, 8'h99, 0, 0, 8'h00, 32'hC381_3C5A);
      vecs[17] = mk(0, 1, 4'd15, 8'h00, 1, 0, 8'h99, 32'hC381_3C5A);
      vecs[18] = mk(1, 0, 4'd2,  8'h7E, 0, 0, 8'h00, 32'hC37E_3C5A);
      vecs[19] = mk(0, 1, 4'd2,  8'h00, 1, 0, 8'h7E, 32'hC37E_3C5A);

      rst = 1'b0;
      drive_a(0, 0, 0, 4'd0, 8'h00);
      drive_b(0, 0, 4'd0, 8'h00);
      b_clr = 1'b0;
      #13;
      check("reset_rdata",  {24'h0, a_rdata}, 32'h0);
      check("reset_valid",  {31'h0, a_valid}, 32'h0);
      check("reset_err",    {31'h0, a_err},   32'h0);
      check("reset_busy",   {31'h0, a_busy},  32'h0);
      check("reset_cfg",    a_cfg,            32'h2081_0000);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Main access table on the 16-deep instance
      last_data = 8'h00;
      for (int i = 0; i < 20; i++) begin
         drive_a(vecs[i].wr, vecs[i].rd, 1'b0, vecs[i].addr, vecs[i].wdata);
         if (vecs[i].exp_valid) begin
            sb_q.push_back(vecs[i].exp_data);
            last_data = vecs[i].exp_data;
         end
         tick();
         check($sformatf("vec%0d_valid", i), {31'h0, a_valid}, {31'h0, vecs[i].exp_valid});
         check($sformatf("vec%0d_err", i),   {31'h0, a_err},   {31'h0, vecs[i].exp_err});
         check($sformatf("vec%0d_cfg", i),   a_cfg,            vecs[i].exp_cfg);
         if (!vecs[i].exp_valid)
            check($sformatf("vec%0d_rd_hold", i), {24'h0, a_rdata}, {24'h0, last_data});
      end
      drive_a(0, 0, 0, 4'd0, 8'h00);
      tick();

      // 12-deep instance: range boundary
      drive_b(0, 1, 4'd2, 8'h00);
      tick();
      check("b_rd2_valid", {31'h0, b_valid}, 32'h1);
      check("b_rd2_err",   {31'h0, b_err},   32'h0);
      check("b_rd2_data",  {24'h0, b_rdata}, 32'h81);
      drive_b(0, 1, 4'd13, 8'h00);
      tick();
      check("b_rd13_valid", {31'h0, b_valid}, 32'h1);
      check("b_rd13_err",   {31'h0, b_err},   32'h1);
      check("b_rd13_data",  {24'h0, b_rdata}, 32'h0);
      drive_b(1, 0, 4'd12, 8'hEE);
      tick();
      check("b_wr12_err",   {31'h0, b_err},   32'h1);
      check("b_wr12_valid", {31'h0, b_valid}, 32'h0);
      drive_b(1, 0, 4'd11, 8'h44);
      tick();
      check("b_wr11_err",   {31'h0, b_err},   32'h0);
      drive_b(0, 1, 4'd11, 8'h00);
      tick();
      check("b_rd11_data",  {24'h0, b_rdata}, 32'h44);
      check("b_rd11_err",   {31'h0, b_err},   32'h0);
      drive_b(0, 1, 4'd12, 8'h00);
      tick();
      check("b_rd12_err",   {31'h0, b_err},   32'h1);
      check("b_rd12_data",  {24'h0, b_rdata}, 32'h0);
      check("b_cfg",        b_cfg,            32'h2081_0000);
      drive_b(0, 0, 4'd0, 8'h00);

      // Fill with 0x55, then sweep back to defaults while the bus keeps trying to access
      for (int i = 0; i < 16; i++) begin
         drive_a(1, 0, 0, 4'(i), 8'h55);
         tick();
         check($sformatf("fill%0d_err", i), {31'h0, a_err}, {31'h0, (i == 4)});
      end
      check("fill_cfg", a_cfg, 32'h5555_5555);
      drive_a(0, 1, 1, 4'd2, 8'h00);
      tick();
      check("clr_drop_valid", {31'h0, a_valid}, 32'h0);
      check("clr_drop_err",   {31'h0, a_err},   32'h0);
      busy_cnt = a_busy ? 1 : 0;
      for (int n = 0; n < 40 && a_busy; n++) begin
         if (n % 2 == 0) drive_a(1, 0, 0, 4'd0, 8'hAA);
         else            drive_a(0, 1, 1, 4'd2, 8'h00);
         tick();
         check($sformatf("sweep%0d_valid", n), {31'h0, a_valid}, 32'h0);
         check($sformatf("sweep%0d_err", n),   {31'h0, a_err},   32'h0);
         if (a_busy) busy_cnt++;
      end
      drive_a(0, 0, 0, 4'd0, 8'h00);
      check("busy_cycles", busy_cnt, 16);
      check("sweep_cfg", a_cfg, 32'h2081_0000);
      for (int i = 0; i < 16; i++) begin
         drive_a(0, 1, 0, 4'(i), 8'h00);
         sb_q.push_back(dflt(i));
         tick();
         check($sformatf("post_sweep%0d_valid", i), {31'h0, a_valid}, 32'h1);
      end
      drive_a(0, 0, 0, 4'd0, 8'h00);
      tick();

      // Reset in the middle of a sweep
      for (int i = 0; i < 16; i++) begin
         drive_a(1, 0, 0, 4'(i), 8'h55);
         tick();
      end
      drive_a(0, 0, 1, 4'd0, 8'h00);
      tick();
      drive_a(0, 0, 0, 4'd0, 8'h00);
      for (int n = 0; n < 7; n++) tick();
      check("mid_busy_before_rst", {31'h0, a_busy}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_busy",  {31'h0, a_busy},  32'h0);
      check("mid_rst_rdata", {24'h0, a_rdata}, 32'h0);
      check("mid_rst_cfg",   a_cfg,            32'h2081_0000);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("after_rst_busy", {31'h0, a_busy}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         drive_a(0, 1, 0, 4'(i), 8'h00);
         sb_q.push_back(dflt(i));
         tick();
         check($sformatf("post_rst%0d_valid", i), {31'h0, a_valid}, 32'h1);
      end
      drive_a(0, 0, 0, 4'd0, 8'h00);
      tick();

`ifdef REGFILE_PARITY_EN
      begin
         logic [15:0] pv;
         drive_a(1, 0, 0, 4'd7, 8'h0F);
         tick();
         drive_a(0, 0, 0, 4'd0, 8'h00);
         pv = dut_a.par_q;
         force dut_a.par_q = pv ^ 16'h0080;
         drive_a(0, 1, 0, 4'd7, 8'h00);
         sb_q.push_back(8'h0F);
         tick();
         check("par_rd7_valid", {31'h0, a_valid}, 32'h1);
         check("par_rd7_err",   {31'h0, a_par},   32'h1);
         drive_a(0, 1, 0, 4'd2, 8'h00);
         sb_q.push_back(8'h81);
         tick();
         check("par_rd2_err",   {31'h0, a_par},   32'h0);
         release dut_a.par_q;
         drive_a(0, 0, 0, 4'd0, 8'h00);
         tick();
      end
`endif

      @(negedge clk);
      check("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
